// File: rtl/fitness_timer_pkg.sv
// Shared constants for the fitness timer: clock rate, default debounce/long-press
// timings and button index assignments.
package fitness_timer_pkg;

    localparam int unsigned CLK_HZ                  = 40_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 400_000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 80_000_000;

    localparam int unsigned NUM_BTNS  = 3;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_SKIP  = 1;
    localparam int unsigned BTN_RESET = 2;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchroniser, stable-count debounce and a
// combinational qualifier for the 0->1 transition of the debounced level.
module debounce_cell
    import fitness_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          meta;
    logic          s;
    logic [CW-1:0] cnt;
    logic          differ_c;
    logic          settle_c;

    assign differ_c = (s != level);
    assign settle_c = differ_c && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise_c   = settle_c && s;

    // cnt only ever climbs to DEBOUNCE_CYCLES-1 before it is cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= raw;
            s    <= meta;
            if (!differ_c) begin
                cnt <= '0;
            end else if (settle_c) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-pin front end for the fitness timer: debounced button pulses with
// priority arbitration, long-press detection on reset, and a debounced switch bus.
module input_conditioner
    import fitness_timer_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 9,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_start_raw,
    input  logic                btn_skip_raw,
    input  logic                btn_reset_raw,
    input  logic [SW_WIDTH-1:0] switches_raw,
    output logic                start_pulse,
    output logic                skip_pulse,
    output logic                reset_pulse,
    output logic                long_reset_pulse,
    output logic [2:0]          btn_level,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic                sw_changed
);

    localparam int unsigned SCW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned LW  = $clog2(LONG_CYCLES) + 1;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] rise_c;
    logic [NUM_BTNS-1:0] win_c;

    assign btn_raw[BTN_START] = btn_start_raw;
    assign btn_raw[BTN_SKIP]  = btn_skip_raw;
    assign btn_raw[BTN_RESET] = btn_reset_raw;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[g]),
            .level (btn_level[g]),
            .rise_c(rise_c[g])
        );
    end

    // Same-edge presses: only the highest priority one survives (reset > skip > start)
    always_comb begin
        win_c = '0;
        if (rise_c[BTN_RESET]) begin
            win_c[BTN_RESET] = 1'b1;
        end else if (rise_c[BTN_SKIP]) begin
            win_c[BTN_SKIP] = 1'b1;
        end else if (rise_c[BTN_START]) begin
            win_c[BTN_START] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_pulse <= 1'b0;
            skip_pulse  <= 1'b0;
            reset_pulse <= 1'b0;
        end else begin
            start_pulse <= win_c[BTN_START];
            skip_pulse  <= win_c[BTN_SKIP];
            reset_pulse <= win_c[BTN_RESET];
        end
    end

    // Long press: lcnt parks at LONG_CYCLES after firing so only one pulse per hold
    logic [LW-1:0] lcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt             <= '0;
            long_reset_pulse <= 1'b0;
        end else begin
            long_reset_pulse <= 1'b0;
            if (!btn_level[BTN_RESET]) begin
                lcnt <= '0;
            end else if (lcnt == LW'(LONG_CYCLES - 1)) begin
                lcnt             <= LW'(LONG_CYCLES);
                long_reset_pulse <= 1'b1;
            end else if (lcnt != LW'(LONG_CYCLES)) begin
                lcnt <= lcnt + LW'(1);
            end
        end
    end

    // Switch bus: accept a new value only after it has held unchanged long enough
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_s;
    logic [SW_WIDTH-1:0] sw_prev;
    logic [SCW-1:0]      scnt;
    logic                sw_hold_c;

    assign sw_hold_c = (sw_s == sw_prev) && (sw_s != sw_stable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta    <= '0;
            sw_s       <= '0;
            sw_prev    <= '0;
            scnt       <= '0;
            sw_stable  <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_meta    <= switches_raw;
            sw_s       <= sw_meta;
            sw_prev    <= sw_s;
            sw_changed <= 1'b0;
            if (!sw_hold_c) begin
                scnt <= '0;
            end else if (scnt == SCW'(DEBOUNCE_CYCLES - 1)) begin
                scnt       <= '0;
                sw_stable  <= sw_s;
                sw_changed <= 1'b1;
            end else begin
                scnt <= scnt + SCW'(1);
            end
        end
    end

endmodule
